// File: rtl/gpio_countdown.sv
// gpio_countdown: user-project GPIO peripheral for the 8-pin user bank.
// After start it raises ready and samples a count from the pins while the
// host still drives them. It then takes over the pins and counts down to 0,
// holding 0 with done set until reset.
module gpio_countdown #(
    parameter int WIDTH        = 8,
    parameter int SAMPLE_DELAY = 10,  // ready -> input sample, must be < DRIVE_DELAY
    parameter int DRIVE_DELAY  = 25,  // ready -> output enable
    parameter int STEP_CYCLES  = 16   // cycles each count value is held, >= 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             ready,
    output logic             done
);

    // Counter widths. The delay counter only has to reach DRIVE_DELAY-1.
    // The step counter needs at least one bit even when STEP_CYCLES is 1.
    localparam int DLY_W  = (DRIVE_DELAY > 1) ? $clog2(DRIVE_DELAY) : 1;
    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [DLY_W-1:0]  SAMPLE_LAST = DLY_W'(SAMPLE_DELAY - 1);
    localparam logic [DLY_W-1:0]  DRIVE_LAST  = DLY_W'(DRIVE_DELAY - 1);
    localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(STEP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT_SAMPLE = 3'd1,
        S_WAIT_DRIVE  = 3'd2,
        S_COUNT       = 3'd3,
        S_DONE        = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [DLY_W-1:0]  delay_q, delay_d;
    logic [STEP_W-1:0] step_q,  step_d;
    logic [WIDTH-1:0]  count_q, count_d;

    // The pad-facing outputs are registered so the pads never see decode glitches.
    logic [WIDTH-1:0]  gpio_out_q, gpio_out_d;
    logic [WIDTH-1:0]  gpio_oe_q,  gpio_oe_d;
    logic              ready_q,    ready_d;
    logic              done_q,     done_d;

    // Next-state logic: sequencing, delay/step counters and the count register.
    always_comb begin
        // NOTE: every variable gets a default here, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        delay_d = delay_q;
        step_d  = step_q;
        count_d = count_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT_SAMPLE;
                    delay_d = '0;
                end
            end

            S_WAIT_SAMPLE: begin
                delay_d = delay_q + 1'b1;
                if (delay_q == SAMPLE_LAST) begin
                    count_d = gpio_in;
                    state_d = S_WAIT_DRIVE;
                end
            end

            S_WAIT_DRIVE: begin
                // gpio_in is no longer looked at; the host may release the pins.
                if (delay_q == DRIVE_LAST) begin
                    state_d = S_COUNT;
                    step_d  = '0;
                end else begin
                    delay_d = delay_q + 1'b1;
                end
            end

            S_COUNT: begin
                if (step_q == STEP_LAST) begin
                    if (count_q != '0) begin
                        // Decrement only above zero, so the count cannot wrap to all ones.
                        count_d = count_q - 1'b1;
                        step_d  = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    step_d = step_q + 1'b1;
                end
            end

            S_DONE: begin
                // Hold until reset.
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs line up with the state register.
    always_comb begin
        ready_d    = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        gpio_oe_d  = {WIDTH{(state_d == S_COUNT) || (state_d == S_DONE)}};
        gpio_out_d = (state_d == S_COUNT) ? count_d : '0;
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q    <= S_IDLE;
            delay_q    <= '0;
            step_q     <= '0;
            count_q    <= '0;
            gpio_out_q <= '0;
            gpio_oe_q  <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            delay_q    <= delay_d;
            step_q     <= step_d;
            count_q    <= count_d;
            gpio_out_q <= gpio_out_d;
            gpio_oe_q  <= gpio_oe_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign gpio_out = gpio_out_q;
    assign gpio_oe  = gpio_oe_q;
    assign ready    = ready_q;
    assign done     = done_q;

endmodule

// File: tb/tb_gpio_countdown.sv
// Directed testbench for gpio_countdown. The expected values come from the
// sequence timing: the sample happens 10 cycles after ready rises, the output
// enable comes 25 cycles after ready, and each value is held for 16 cycles.
module tb_gpio_countdown;

    localparam int WIDTH = 8;
    localparam int SDLY  = 10;
    localparam int DDLY  = 25;
    localparam int STEP  = 16;

    logic             clock;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] gpio_in;
    logic [WIDTH-1:0] gpio_out;
    logic [WIDTH-1:0] gpio_oe;
    logic             ready;
    logic             done;

    int n_pass  = 0;
    int n_total = 0;

    gpio_countdown #(
        .WIDTH        (WIDTH),
        .SAMPLE_DELAY (SDLY),
        .DRIVE_DELAY  (DDLY),
        .STEP_CYCLES  (STEP)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .ready    (ready),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 32'(ready), 32'd0);
        check({tag, "_oe"},    32'(gpio_oe), 32'd0);
        check({tag, "_out"},   32'(gpio_out), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
    endtask

    // Raise start with value v on the pins; returns in cycle 0 after ready rises.
    task automatic launch(input logic [WIDTH-1:0] v);
        gpio_in = v;
        start   = 1'b1;
        tick();
    endtask

    // Cycles 0..DDLY-1 after ready: pins are inputs. Optionally change the
    // pin value or release the pins partway through; start drops at cycle 2.
    task automatic wait_phase(input int change_at, input logic [WIDTH-1:0] change_val,
                              input int release_at);
        for (int k = 0; k < DDLY; k++) begin
            if (k == 2) start = 1'b0;
            if (k == change_at) gpio_in = change_val;
            if (k == release_at) gpio_in = 'z;
            check("wait_ready", 32'(ready), 32'd1);
            check("wait_oe", 32'(gpio_oe), 32'd0);
            check("wait_done", 32'(done), 32'd0);
            tick();
        end
    endtask

    // Counting phase from value 'from' down to 0, each value held STEP cycles.
    // Stops early (aborted=1) at step 5 of value abort_val.
    task automatic count_phase(input int from, input int abort_val, output bit aborted);
        aborted = 1'b0;
        for (int v = from; v >= 0; v--) begin
            for (int s = 0; s < STEP; s++) begin
                if (v == abort_val && s == 5) begin
                    aborted = 1'b1;
                    return;
                end
                check("cnt_out", 32'(gpio_out), 32'(v));
                check("cnt_oe", 32'(gpio_oe), 32'hff);
                check("cnt_done", 32'(done), 32'd0);
                tick();
            end
        end
        for (int h = 0; h < 4; h++) begin
            check("done_flag", 32'(done), 32'd1);
            check("done_out", 32'(gpio_out), 32'd0);
            check("done_oe", 32'(gpio_oe), 32'hff);
            check("done_ready", 32'(ready), 32'd1);
            tick();
        end
    endtask

    task automatic do_reset();
        start = 1'b0;
        reset = 1'b1;
        tick();
        check_idle("rst");
        reset = 1'b0;
    endtask

    initial begin
        bit aborted;

        // Reset hold, then release with start low: everything stays 0.
        reset   = 1'b1;
        start   = 1'b0;
        gpio_in = 8'h00;
        repeat (3) tick();
        check_idle("reset_hold");
        reset   = 1'b0;
        gpio_in = 8'haa;
        for (int i = 0; i < 20; i++) begin
            check_idle("idle");
            tick();
        end

        // 21 on the pins, host releases them at cycle 19.
        launch(8'd21);
        wait_phase(-1, 8'd0, 19);
        count_phase(21, -1, aborted);
        check("t21_no_abort", 32'(aborted), 32'd0);
        do_reset();

        // Pins change from 21 to 7 after the sample point: count still starts at 21.
        launch(8'd21);
        wait_phase(12, 8'd7, 19);
        count_phase(21, -1, aborted);
        do_reset();

        // Zero: a single 0 phase, then done, with no wrap to 255.
        launch(8'd0);
        wait_phase(-1, 8'd0, 19);
        count_phase(0, -1, aborted);
        do_reset();

        // 255: the full descending range.
        launch(8'd255);
        wait_phase(-1, 8'd0, 19);
        count_phase(255, -1, aborted);
        do_reset();

        // Reset in the middle of the count at value 9, then a fresh start.
        launch(8'd12);
        wait_phase(-1, 8'd0, 19);
        count_phase(12, 9, aborted);
        check("abort_reached", 32'(aborted), 32'd1);
        check("mid_out_9", 32'(gpio_out), 32'd9);
        reset = 1'b1;
        tick();
        check_idle("mid_reset");
        reset = 1'b0;
        tick();
        check_idle("after_mid_reset");
        launch(8'd3);
        wait_phase(-1, 8'd0, 19);
        count_phase(3, -1, aborted);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gpio_countdown.md
Name: gpio_countdown

Overview:
- User-project GPIO peripheral on the 8-pin user GPIO bank (mprj_io[10:3]), plus a status pin on mprj_io[37].
- Once the core is programmed, it announces readiness and samples an 8-bit count from the pins while the host drives them.
- It then turns the pins to outputs and counts down from the sampled value to 0, holding 0 at the end.
- Sits between the processor's boot/ready logic and the Caravel GPIO pad controls (out/oe).

Parameters:
- WIDTH, 8, GPIO bank width and counter width.
- SAMPLE_DELAY, 10, cycles from ready assertion to input sample; must be less than DRIVE_DELAY.
- DRIVE_DELAY, 25, cycles from ready assertion to output-enable assertion. Gives the host time to release the pins.
- STEP_CYCLES, 16, cycles each count value is held on the pins; minimum 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; high once program load/boot has completed. Sampled in IDLE only.
- gpio_in  in  WIDTH  pad input values.
- gpio_out  out  WIDTH  pad output values.
- gpio_oe  out  WIDTH  pad output enables, all bits equal; 1 = drive.
- ready  out  1  programmed/ready flag, routed to mprj_io[37].
- done  out  1  high once the count has reached 0.

Behaviour:
- Reset (synchronous, active-high, clock rising edge) puts the block in IDLE.
  - All outputs are 0: gpio_out=0, gpio_oe=0, ready=0, done=0.
  - Internal delay counter, step counter and count register are cleared.
- State machine: IDLE -> WAIT_SAMPLE -> WAIT_DRIVE -> COUNT -> DONE.
- IDLE: when start=1 at a rising edge, go to WAIT_SAMPLE, set ready=1 and clear the delay counter.
- ready stays 1 in every state after IDLE, until reset.
- WAIT_SAMPLE:
  - The delay counter increments each cycle.
  - When it reaches SAMPLE_DELAY-1, latch gpio_in into the count register and go to WAIT_DRIVE.
  - gpio_oe stays 0.
- WAIT_DRIVE:
  - The delay counter continues.
  - When it reaches DRIVE_DELAY-1, go to COUNT: gpio_oe=all ones, gpio_out=latched value, step counter=0.
  - gpio_in is ignored from here on.
- COUNT:
  - gpio_out always equals the count register.
  - The step counter increments each cycle.
  - At STEP_CYCLES-1: if count>0, decrement it and clear the step counter; if count==0, go to DONE.
  - Each value N..0 is therefore visible for exactly STEP_CYCLES cycles, and no value is skipped.
- DONE: done=1, gpio_oe stays all ones, gpio_out=0. Held until reset.
- Arithmetic and boundary rules:
  - The count is unsigned WIDTH bits and never wraps below 0.
  - A sampled value of 0 gives a single 0 phase of STEP_CYCLES cycles, then DONE.
  - Sampled value 255 counts the full range.
- start deasserting after IDLE has no effect; the sequence completes.
- Reset asserted in any state returns to IDLE with reset values on the next edge, including mid-count. gpio_oe drops immediately on that edge.
- gpio_oe must never be 1 before DRIVE_DELAY cycles after ready rises, so there is no pin contention with the host.

Test Plan:
- Reset hold, then release with start=0 -> all outputs 0 indefinitely; gpio_oe=0.
- Drive gpio_in=21, raise start, release pins (z) after 19 cycles:
  - ready=1 the cycle after start.
  - gpio_oe=0 until cycle 25 after ready.
  - gpio_out then shows 21,20,...,0, each for 16 cycles.
  - done=1 after 0 has been held.
- gpio_in=0 -> gpio_out=0 for 16 cycles, then done=1; no wrap to 255.
- gpio_in=255 -> 256 distinct descending values observed, then done=1.
- Change gpio_in after the sample point (e.g. from 21 to 7 at cycle 12) -> count still starts at 21.
- Assert reset mid-count (at value 9) -> next edge gpio_oe=0, ready=0, done=0. A new start resamples gpio_in and restarts the sequence.
